// File: rtl/gate_exerciser.sv
// Drives {A,B} through all four rows, samples dut_y after SETTLE cycles per row, checks against EXPECTED.
// Latency: done pulses 4*SETTLE*PASSES cycles after the start edge; one IDLE cycle separates back-to-back runs.
// Backpressure: none; start is only sampled in IDLE and ignored while busy.
module gate_exerciser #(
  parameter logic [3:0] EXPECTED = 4'b0111,
  parameter int         SETTLE   = 2,
  parameter int         PASSES   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       A,
  output logic       B,
  input  logic       dut_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask
);

  // A SETTLE of 0 would never sample; clamp into the 1..255 range the 8-bit counter supports.
  localparam int         SETTLE_EFF = (SETTLE < 1) ? 1 : ((SETTLE > 255) ? 255 : SETTLE);
  localparam int         PASSES_EFF = (PASSES < 1) ? 1 : ((PASSES > 15) ? 15 : PASSES);
  localparam logic [7:0] RELOAD     = 8'(SETTLE_EFF - 1);
  localparam logic [3:0] LAST_PASS  = 4'(PASSES_EFF - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  ab_q, ab_d;
  logic [1:0]  row_q, row_d;
  logic [3:0]  pcnt_q, pcnt_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [3:0]  mask_q, mask_d;
  logic [3:0]  mask_upd;

  // Next-state and output decode; the final-row mismatch is folded into mask_upd so pass sees it on the done edge.
  always_comb begin
    state_d  = state_q;
    ab_d     = ab_q;
    row_d    = row_q;
    pcnt_d   = pcnt_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    mask_d   = mask_q;
    mask_upd = mask_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          ab_d    = 2'b00;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          mask_d  = 4'b0000;
          cnt_d   = RELOAD;
          row_d   = 2'd0;
          pcnt_d  = 4'd0;
        end
      end
      S_RUN: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          if (dut_y != EXPECTED[row_q]) begin
            mask_upd = mask_q | (4'b0001 << row_q);
          end
          mask_d = mask_upd;
          if (row_q != 2'd3) begin
            row_d = row_q + 2'd1;
            ab_d  = row_q + 2'd1;
            cnt_d = RELOAD;
          end else if (pcnt_q != LAST_PASS) begin
            pcnt_d = pcnt_q + 4'd1;
            row_d  = 2'd0;
            ab_d   = 2'b00;
            cnt_d  = RELOAD;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (mask_upd == 4'b0000);
            ab_d    = 2'b00;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous active-low reset; reset aborts a run and clears all results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ab_q    <= 2'b00;
      row_q   <= 2'd0;
      pcnt_q  <= 4'd0;
      cnt_q   <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mask_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      ab_q    <= ab_d;
      row_q   <= row_d;
      pcnt_q  <= pcnt_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      mask_q  <= mask_d;
    end
  end

  assign A         = ab_q[1];
  assign B         = ab_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = mask_q;

endmodule

// File: tb/tb_gate_exerciser.sv
// Directed bench: three exerciser instances (NAND SETTLE=2/PASSES=1, SETTLE=1/PASSES=3, SETTLE=0/PASSES=1)
// each driving a small behavioural gate model; expected values are hand-computed from the sweep timing.
// Checks are immediate assertions; failures are counted and reported, then a single summary line.
module tb_gate_exerciser;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance 0: default NAND, SETTLE=2, PASSES=1; model selectable (0 correct, 1 stuck-1, 2 stuck-0)
  logic start0, a0, b0, y0, busy0, done0, pass0;
  logic [3:0] mask0;
  int mode0 = 0;
  assign y0 = (mode0 == 0) ? ~(a0 & b0) : ((mode0 == 1) ? 1'b1 : 1'b0);

  gate_exerciser #(.EXPECTED(4'b0111), .SETTLE(2), .PASSES(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .A(a0), .B(b0), .dut_y(y0),
    .busy(busy0), .done(done0), .pass(pass0), .fail_mask(mask0)
  );

  // Instance 1: SETTLE=1, PASSES=3; model wrong only on the second visit to row 01
  logic start1, a1, b1, y1, busy1, done1, pass1;
  logic [3:0] mask1;
  int v01 = 0;
  always @(negedge clk) begin
    if (!busy1) v01 <= 0;
    else if ({a1, b1} == 2'b01) v01 <= v01 + 1;
  end
  assign y1 = ~(a1 & b1) ^ (({a1, b1} == 2'b01) && (v01 == 2));

  gate_exerciser #(.EXPECTED(4'b0111), .SETTLE(1), .PASSES(3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1), .dut_y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_mask(mask1)
  );

  // Instance 2: SETTLE=0 must behave as SETTLE=1
  logic start2, a2, b2, y2, busy2, done2, pass2;
  logic [3:0] mask2;
  assign y2 = ~(a2 & b2);

  gate_exerciser #(.EXPECTED(4'b0111), .SETTLE(0), .PASSES(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .A(a2), .B(b2), .dut_y(y2),
    .busy(busy2), .done(done2), .pass(pass2), .fail_mask(mask2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full run on u0 with per-cycle checks of the vector sequence, busy window and done timing.
  task automatic run0(input int mode, input bit glitch, input bit exp_pass, input logic [3:0] exp_mask,
                      input string tag);
    mode0 = mode;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk({tag, "_ab"}, {30'd0, a0, b0}, k / 2);
      chk({tag, "_busy"}, busy0, 1);
      chk({tag, "_done_early"}, done0, 0);
      start0 = glitch && (k == 1 || k == 3);
      tick();
    end
    start0 = 1'b0;
    chk({tag, "_done"}, done0, 1);
    chk({tag, "_busy_end"}, busy0, 0);
    chk({tag, "_pass"}, pass0, exp_pass);
    chk({tag, "_mask"}, mask0, exp_mask);
    chk({tag, "_ab_end"}, {a0, b0}, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk({tag, "_done_clr"}, done0, 0);
      chk({tag, "_pass_hold"}, pass0, exp_pass);
      chk({tag, "_mask_hold"}, mask0, exp_mask);
    end
  endtask

  initial begin
    int n;
    int ndone;
    int t_done[$];
    logic p_done[$];
    bit got;

    rst_n = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    tick();
    tick();
    chk("rst_u0", {a0, b0, busy0, done0, pass0, mask0}, 0);
    chk("rst_u1", {a1, b1, busy1, done1, pass1, mask1}, 0);
    chk("rst_u2", {a2, b2, busy2, done2, pass2, mask2}, 0);
    rst_n = 1'b1;
    tick();

    // Correct NAND model
    run0(0, 0, 1'b1, 4'b0000, "nand_ok");
    // Output stuck at 1: only row 11 (expects 0) mismatches
    run0(1, 0, 1'b0, 4'b1000, "stuck1");

    // Reset mid-run with a stuck-0 model so the mask is non-zero before reset
    mode0 = 2;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("midrst_mask_pre", mask0, 4'b0011);
    chk("midrst_busy_pre", busy0, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_ab", {a0, b0}, 0);
    chk("midrst_busy", busy0, 0);
    chk("midrst_mask", mask0, 0);
    chk("midrst_done", done0, 0);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done0) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    run0(0, 0, 1'b1, 4'b0000, "after_rst");

    // start pulses during the run must not disturb it
    run0(0, 1, 1'b1, 4'b0000, "glitch");

    // start held high for 40 cycles: dones at 9,18,27,36; model switched so pass differs per run
    mode0 = 0;
    start0 = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (done0) begin
        t_done.push_back(t);
        p_done.push_back(pass0);
        mode0 = (t_done.size() == 1) ? 1 : 0;
      end
    end
    start0 = 1'b0;
    chk("held_count", t_done.size(), 4);
    for (int i = 0; i < t_done.size() && i < 4; i++) begin
      chk("held_time", t_done[i], 9 * (i + 1));
      chk("held_pass", p_done[i], (i == 1) ? 0 : 1);
    end
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      if (done0) got = 1'b1;
    end
    chk("held_tail_done", got, 1);
    chk("held_tail_pass", pass0, 1);

    // PASSES=3, SETTLE=1: sticky error from second visit to row 01
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n = 0;
    while (!done1 && n < 30) begin
      tick();
      n++;
    end
    chk("p3_latency", n, 12);
    chk("p3_mask", mask1, 4'b0010);
    chk("p3_pass", pass1, 0);

    // SETTLE=0 acts as SETTLE=1
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    n = 0;
    while (!done2 && n < 30) begin
      tick();
      n++;
    end
    chk("s0_latency", n, 4);
    chk("s0_pass", pass2, 1);
    chk("s0_mask", mask2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
